// File: rtl/pipe_pkg.sv
// Shared encodings for the elastic pipeline stage: FSM states, default widths, bubble control.
// Control-bit indices describe the core's packing of the ctrl vector.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam int DATA_W_DEF = 128;
    localparam int CTRL_W_DEF = 10;
    localparam int CNT_W_DEF  = 16;

    localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;

    localparam int CB_ALUOP0   = 0;
    localparam int CB_ALUOP1   = 1;
    localparam int CB_ALUSRC   = 2;
    localparam int CB_MEMREAD  = 3;
    localparam int CB_MEMWRITE = 4;
    localparam int CB_REGWRITE = 5;
    localparam int CB_MEMTOREG = 6;
    localparam int CB_BRANCH   = 7;
    localparam int CB_JUMP     = 8;
    localparam int CB_REGDST   = 9;

endpackage

// File: rtl/pipe_slot.sv
// One buffer entry: valid flag plus payload register; load wins over clear.
// Latency 1 cycle; clear drops only the valid flag so the payload keeps its last value.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic         vld_o,
    output logic [W-1:0] q_o
);

    logic         vld_q;
    logic [W-1:0] dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else if (ld_i) begin
            vld_q <= 1'b1;
            dat_q <= d_i;
        end else if (clr_i) begin
            vld_q <= 1'b0;
        end
    end

    assign vld_o = vld_q;
    assign q_o   = dat_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic main+skid pipeline register, 1-cycle latency, full throughput; in_ready low only when both slots full.
// Flush squashes held and offered beats. Optional perf counters under PIPE_STAGE_PERF_EN.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int CNT_W  = CNT_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    localparam int PW = DATA_W + CTRL_W;

    state_e          state_q, state_d;
    logic            accept, drain;
    logic            main_ld, main_sel_skid, skid_ld;
    logic            main_vld, skid_vld;
    logic [PW-1:0]   in_pay, main_d, main_q, skid_q;

    assign in_ready = (state_q != ST_TWO);
    assign accept   = in_valid & in_ready;
    assign drain    = main_vld & out_ready;
    assign in_pay   = {in_data, in_ctrl};
    assign main_d   = main_sel_skid ? skid_q : in_pay;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        main_ld       = 1'b0;
        main_sel_skid = 1'b0;
        skid_ld       = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) begin
                    state_d = ST_ONE;
                    main_ld = 1'b1;
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_ld = 1'b1;
                    end else if (accept) begin
                        state_d = ST_TWO;
                        skid_ld = 1'b1;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: if (drain && skid_vld) begin
                    state_d       = ST_ONE;
                    main_ld       = 1'b1;
                    main_sel_skid = 1'b1;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    pipe_slot #(.W(PW)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (main_ld),
        .clr_i (flush | drain),
        .d_i   (main_d),
        .vld_o (main_vld),
        .q_o   (main_q)
    );

    pipe_slot #(.W(PW)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (skid_ld),
        .clr_i (flush | main_sel_skid),
        .d_i   (in_pay),
        .vld_o (skid_vld),
        .q_o   (skid_q)
    );

    // Bubbles carry zero control so nothing downstream acts on stale bits.
    assign out_valid = main_vld;
    assign out_data  = main_q[PW-1:CTRL_W];
    assign out_ctrl  = main_vld ? main_q[CTRL_W-1:0] : CTRL_W'(CTRL_BUBBLE);

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (main_vld && !out_ready && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush && (main_vld || accept) && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic with a queue scoreboard on the output handshake.
module tb_pipe_stage_elastic;

    localparam int DW = 128;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, out_ready;
    logic          in_ready, out_valid;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] in_ctrl, out_ctrl;

    int checks   = 0;
    int failures = 0;
    logic [DW+CW-1:0] sb[$];

    always #5 clk = ~clk;

`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_in_ready, s_out_valid;
    logic [DW-1:0] s_out_data;
    logic [CW-1:0] s_out_ctrl;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );
`endif

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold a beat on the input until the stage takes it; returns just after the accepting edge.
    task automatic offer(input logic [DW-1:0] d, input logic [CW-1:0] c);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("offer_accept", DW'(in_ready), DW'(1));
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on accept, pop and compare on drain, drop everything on flush/reset.
    always @(negedge clk) begin
        logic [DW+CW-1:0] exp;
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("sb_nonempty", DW'(sb.size() != 0), DW'(1));
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    check("out_data", out_data, exp[DW+CW-1:CW]);
                    check("out_ctrl", DW'(out_ctrl), DW'(exp[CW-1:0]));
                end
            end
            if (in_valid && in_ready) sb.push_back({in_data, in_ctrl});
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_out_data", out_data, DW'(0));
        check("rst_out_ctrl", DW'(out_ctrl), DW'(0));
        check("rst_in_ready", DW'(in_ready), DW'(1));
        rst_n = 1'b1;

        // Single beat, one-cycle latency
        in_valid = 1'b1; in_data = DW'(8'hA5); in_ctrl = 10'h3FF; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t1_out_valid", DW'(out_valid), DW'(1));
        check("t1_out_data", out_data, DW'(8'hA5));
        check("t1_out_ctrl", DW'(out_ctrl), DW'(10'h3FF));
        @(posedge clk); #1;

        // Back-to-back stream at full rate
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = DW'(i); in_ctrl = CW'(i * 37);
            @(negedge clk);
            check("t2_in_ready", DW'(in_ready), DW'(1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t2_sb_drained", DW'(sb.size()), DW'(0));

        // Back-pressure fills both slots, third beat waits upstream
        out_ready = 1'b0;
        offer(DW'(1), CW'(1));
        offer(DW'(2), CW'(2));
        in_valid = 1'b1; in_data = DW'(3); in_ctrl = CW'(3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_in_ready_low", DW'(in_ready), DW'(0));
            check("t3_head_held", out_data, DW'(1));
        end
        out_ready = 1'b1;
        offer(DW'(3), CW'(3));
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t3_sb_drained", DW'(sb.size()), DW'(0));

        // Flush while full with a beat offered
        out_ready = 1'b0;
        offer(DW'(5), CW'(5));
        offer(DW'(6), CW'(6));
        in_valid = 1'b1; in_data = DW'(7); in_ctrl = CW'(7); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("t4_out_valid", DW'(out_valid), DW'(0));
        check("t4_out_ctrl", DW'(out_ctrl), DW'(0));
        check("t4_out_data_kept", out_data, DW'(5));
        check("t4_in_ready", DW'(in_ready), DW'(1));
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t4_no_beats", DW'(out_valid), DW'(0));

        // Asynchronous reset while full
        out_ready = 1'b0;
        offer(DW'(9), CW'(9));
        offer(DW'(10), CW'(10));
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t5_out_valid", DW'(out_valid), DW'(0));
        check("t5_out_data", out_data, DW'(0));
        check("t5_out_ctrl", DW'(out_ctrl), DW'(0));
        check("t5_in_ready", DW'(in_ready), DW'(1));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

`ifdef PIPE_STAGE_PERF_EN
        check("t6_stall_rst", DW'(stall_cnt), DW'(0));
        check("t6_flush_rst", DW'(flush_cnt), DW'(0));
        offer(DW'(11), CW'(11));
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("t6_stall_cnt", DW'(stall_cnt), DW'(5));
        check("t6_flush_cnt", DW'(flush_cnt), DW'(1));
        check("t6_stall_sat", DW'(s_stall_cnt), DW'(3));
        check("t6_flush_sat", DW'(s_flush_cnt), DW'(1));
`endif

        check("final_sb_empty", DW'(sb.size()), DW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
